// File: rtl/vision_seq_ctrl.sv
// Top-level sequencer for the camera vision pipeline. It issues capture and
// min/max requests over start/ack handshakes, with a timeout on every wait
// state. It latches the bounding box and its centre for overlap_image.
`timescale 1ns/1ps
module vision_seq_ctrl #(
    parameter int unsigned PH_TIMEOUT = 2_000_000,
    parameter int unsigned MM_TIMEOUT = 2_000_000,
    parameter bit          SKIP_PHOTO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        continuous,
    input  logic        clear_err,
    output logic        photo_start,
    output logic        photo_ack,
    input  logic        photo_started,
    input  logic        photo_done,
    input  logic        photo_error,
    output logic        mm_start,
    output logic        mm_ack,
    input  logic        mm_done,
    input  logic        mm_error,
    input  logic [8:0]  x_min_in,
    input  logic [8:0]  x_max_in,
    input  logic [8:0]  y_min_in,
    input  logic [8:0]  y_max_in,
    output logic [8:0]  x_min,
    output logic [8:0]  x_max,
    output logic [8:0]  y_min,
    output logic [8:0]  y_max,
    output logic [8:0]  x_cen,
    output logic [8:0]  y_cen,
    output logic        box_valid,
    output logic        box_empty,
    output logic [15:0] frame_count,
    output logic        err_flag,
    output logic [1:0]  err_code,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        PH_REQ  = 4'd1,
        PH_EXEC = 4'd2,
        PH_ACK  = 4'd3,
        MM_REQ  = 4'd4,
        MM_ACK  = 4'd5,
        ERROR   = 4'd7
    } state_t;

    state_t      state, nxt, start_st;
    logic        run_q;
    logic [31:0] tmr;
    logic [1:0]  nxt_code;
    logic        latch_box;
    logic        frame_end;
    logic        ph_to, mm_to;
    logic [15:0] frame_cnt_q;

    // Midpoint of two 9-bit coordinates: the 10-bit sum is truncated by one bit
    function automatic logic [8:0] midpoint(input logic [8:0] a, input logic [8:0] b);
        logic [9:0] s;
        s = {1'b0, a} + {1'b0, b};
        return 9'(s >> 1);
    endfunction

    assign ph_to       = (PH_TIMEOUT != 0) && (tmr == PH_TIMEOUT - 32'd1);
    assign mm_to       = (MM_TIMEOUT != 0) && (tmr == MM_TIMEOUT - 32'd1);
    assign frame_count = frame_cnt_q;

    // Next-state decode; a fault input takes precedence over the handshake it accompanies
    always_comb begin
        nxt       = state;
        nxt_code  = 2'd0;
        latch_box = 1'b0;
        frame_end = 1'b0;
        if (SKIP_PHOTO) start_st = MM_REQ;
        else            start_st = PH_REQ;
        case (state)
            IDLE: begin
                if (run && (continuous || !run_q)) nxt = start_st;
            end
            PH_REQ: begin
                if (photo_error)        begin nxt = ERROR; nxt_code = 2'd1; end
                else if (photo_started) nxt = PH_EXEC;
                else if (ph_to)         begin nxt = ERROR; nxt_code = 2'd3; end
            end
            PH_EXEC: begin
                if (photo_error)     begin nxt = ERROR; nxt_code = 2'd1; end
                else if (photo_done) nxt = PH_ACK;
                else if (ph_to)      begin nxt = ERROR; nxt_code = 2'd3; end
            end
            PH_ACK: begin
                if (photo_error)      begin nxt = ERROR; nxt_code = 2'd1; end
                else if (!photo_done) nxt = MM_REQ;
                else if (ph_to)       begin nxt = ERROR; nxt_code = 2'd3; end
            end
            MM_REQ: begin
                if (mm_error)     begin nxt = ERROR; nxt_code = 2'd2; end
                else if (mm_done) begin nxt = MM_ACK; latch_box = 1'b1; end
                else if (mm_to)   begin nxt = ERROR; nxt_code = 2'd3; end
            end
            MM_ACK: begin
                if (mm_error) begin
                    nxt      = ERROR;
                    nxt_code = 2'd2;
                end else if (!mm_done) begin
                    frame_end = 1'b1;
                    nxt       = (run && continuous) ? start_st : IDLE;
                end else if (mm_to) begin
                    nxt      = ERROR;
                    nxt_code = 2'd3;
                end
            end
            ERROR: begin
                if (clear_err) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // State, wait timer and handshake outputs, registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            run_q       <= 1'b0;
            tmr         <= '0;
            photo_start <= 1'b0;
            photo_ack   <= 1'b0;
            mm_start    <= 1'b0;
            mm_ack      <= 1'b0;
            err_flag    <= 1'b0;
            err_code    <= 2'd0;
            state_dbg   <= 4'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            state       <= nxt;
            run_q       <= run;
            photo_start <= (nxt == PH_REQ);
            photo_ack   <= (nxt == PH_ACK);
            mm_start    <= (nxt == MM_REQ);
            mm_ack      <= (nxt == MM_ACK);
            err_flag    <= (nxt == ERROR);
            state_dbg   <= nxt;
            if (nxt != state || state == IDLE || state == ERROR) tmr <= '0;
            else                                                  tmr <= tmr + 32'd1;
            if (nxt == ERROR && state != ERROR) err_code <= nxt_code;
            else if (nxt != ERROR)              err_code <= 2'd0;
            if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    // Bounding-box latch: updates only when a clean filter result is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            x_cen     <= '0;
            y_cen     <= '0;
            box_empty <= 1'b0;
            box_valid <= 1'b0;
        end else begin
            box_valid <= latch_box;
            if (latch_box) begin
                x_min     <= x_min_in;
                x_max     <= x_max_in;
                y_min     <= y_min_in;
                y_max     <= y_max_in;
                x_cen     <= midpoint(x_min_in, x_max_in);
                y_cen     <= midpoint(y_min_in, y_max_in);
                box_empty <= (x_min_in > x_max_in) || (y_min_in > y_max_in);
            end
        end
    end

endmodule

// File: tb/tb_vision_seq_ctrl.sv
// Self-checking bench for vision_seq_ctrl: randomized frames against a small
// frame/box model, plus error, timeout, reset and bring-up-mode scenarios.
`timescale 1ns/1ps
module tb_vision_seq_ctrl;

    logic clk_out_25MHZ = 1'b0;
    always #20 clk_out_25MHZ = ~clk_out_25MHZ;

    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    // main instance (photo path enabled, short timeouts)
    logic        m_run, m_cont, m_clr, m_pst, m_pdone, m_perr, m_mdone, m_merr;
    logic [8:0]  m_xmin_i, m_xmax_i, m_ymin_i, m_ymax_i;
    logic        m_photo_start, m_photo_ack, m_mm_start, m_mm_ack;
    logic [8:0]  m_x_min, m_x_max, m_y_min, m_y_max, m_x_cen, m_y_cen;
    logic        m_box_valid, m_box_empty, m_err_flag;
    logic [15:0] m_frame_count;
    logic [1:0]  m_err_code;
    logic [3:0]  m_state;

    // bring-up instance (capture skipped, no min/max timeout)
    logic        s_run, s_cont, s_clr, s_pst, s_pdone, s_perr, s_mdone, s_merr;
    logic [8:0]  s_xmin_i, s_xmax_i, s_ymin_i, s_ymax_i;
    logic        s_photo_start, s_photo_ack, s_mm_start, s_mm_ack;
    logic [8:0]  s_x_min, s_x_max, s_y_min, s_y_max, s_x_cen, s_y_cen;
    logic        s_box_valid, s_box_empty, s_err_flag;
    logic [15:0] s_frame_count;
    logic [1:0]  s_err_code;
    logic [3:0]  s_state;

    // reference model state
    int          exp_fc = 0;
    logic [35:0] e_box = '0;
    logic [17:0] e_cen = '0;
    logic        e_empty = 1'b0;
    int          s_exp_fc = 0;
    logic [35:0] se_box = '0;
    logic [17:0] se_cen = '0;
    logic        se_empty = 1'b0;

    int m_bv_cnt = 0;
    int s_bv_cnt = 0;
    int s_ph_cnt = 0;

    vision_seq_ctrl #(.PH_TIMEOUT(16), .MM_TIMEOUT(16), .SKIP_PHOTO(1'b0)) dut (
        .clk(clk_out_25MHZ), .reset(reset), .run(m_run), .continuous(m_cont), .clear_err(m_clr),
        .photo_start(m_photo_start), .photo_ack(m_photo_ack), .photo_started(m_pst),
        .photo_done(m_pdone), .photo_error(m_perr), .mm_start(m_mm_start), .mm_ack(m_mm_ack),
        .mm_done(m_mdone), .mm_error(m_merr), .x_min_in(m_xmin_i), .x_max_in(m_xmax_i),
        .y_min_in(m_ymin_i), .y_max_in(m_ymax_i), .x_min(m_x_min), .x_max(m_x_max),
        .y_min(m_y_min), .y_max(m_y_max), .x_cen(m_x_cen), .y_cen(m_y_cen),
        .box_valid(m_box_valid), .box_empty(m_box_empty), .frame_count(m_frame_count),
        .err_flag(m_err_flag), .err_code(m_err_code), .state_dbg(m_state));

    vision_seq_ctrl #(.PH_TIMEOUT(16), .MM_TIMEOUT(0), .SKIP_PHOTO(1'b1)) dut_s (
        .clk(clk_out_25MHZ), .reset(reset), .run(s_run), .continuous(s_cont), .clear_err(s_clr),
        .photo_start(s_photo_start), .photo_ack(s_photo_ack), .photo_started(s_pst),
        .photo_done(s_pdone), .photo_error(s_perr), .mm_start(s_mm_start), .mm_ack(s_mm_ack),
        .mm_done(s_mdone), .mm_error(s_merr), .x_min_in(s_xmin_i), .x_max_in(s_xmax_i),
        .y_min_in(s_ymin_i), .y_max_in(s_ymax_i), .x_min(s_x_min), .x_max(s_x_max),
        .y_min(s_y_min), .y_max(s_y_max), .x_cen(s_x_cen), .y_cen(s_y_cen),
        .box_valid(s_box_valid), .box_empty(s_box_empty), .frame_count(s_frame_count),
        .err_flag(s_err_flag), .err_code(s_err_code), .state_dbg(s_state));

    always @(negedge clk_out_25MHZ) begin
        if (m_box_valid)   m_bv_cnt <= m_bv_cnt + 1;
        if (s_box_valid)   s_bv_cnt <= s_bv_cnt + 1;
        if (s_photo_start) s_ph_cnt <= s_ph_cnt + 1;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // box centre from the rule: half of the coordinate sum, integer division
    function automatic logic [17:0] cen_of(input logic [8:0] a, input logic [8:0] b,
                                           input logic [8:0] c, input logic [8:0] d);
        int sx, sy;
        sx = int'(a) + int'(b);
        sy = int'(c) + int'(d);
        return {9'(sx / 2), 9'(sy / 2)};
    endfunction

    task automatic m_frame(input int sd, input int dd, input int md, input bit drop_run,
                           input logic [8:0] a, input logic [8:0] b,
                           input logic [8:0] c, input logic [8:0] d);
        int k;
        int bv0;
        k = 0;
        while (m_photo_start !== 1'b1 && k < 40) begin @(negedge clk_out_25MHZ); k++; end
        n_checks++;
        if (m_photo_start !== 1'b1 || m_state !== 4'd1)
            $display("FAIL frame_req: photo_start=%b state=%0d, want 1/1", m_photo_start, m_state);
        else n_pass++;
        repeat (sd) @(negedge clk_out_25MHZ);
        m_pst = 1'b1;
        @(negedge clk_out_25MHZ);
        m_pst = 1'b0;
        if (drop_run) m_run = 1'b0;
        repeat (dd) @(negedge clk_out_25MHZ);
        m_pdone = 1'b1;
        k = 0;
        while (m_photo_ack !== 1'b1 && k < 40) begin @(negedge clk_out_25MHZ); k++; end
        n_checks++;
        if (m_photo_ack !== 1'b1 || m_state !== 4'd3 || m_photo_start !== 1'b0)
            $display("FAIL frame_ph_ack: ack=%b state=%0d start=%b, want 1/3/0", m_photo_ack, m_state, m_photo_start);
        else n_pass++;
        m_pdone = 1'b0;
        k = 0;
        while (m_mm_start !== 1'b1 && k < 40) begin @(negedge clk_out_25MHZ); k++; end
        n_checks++;
        if (m_mm_start !== 1'b1 || m_state !== 4'd4 || m_photo_ack !== 1'b0)
            $display("FAIL frame_mm_req: mm_start=%b state=%0d ph_ack=%b, want 1/4/0", m_mm_start, m_state, m_photo_ack);
        else n_pass++;
        repeat (md) @(negedge clk_out_25MHZ);
        m_xmin_i = a; m_xmax_i = b; m_ymin_i = c; m_ymax_i = d;
        m_mdone = 1'b1;
        e_box   = {a, b, c, d};
        e_cen   = cen_of(a, b, c, d);
        e_empty = (a > b) || (c > d);
        bv0 = m_bv_cnt;
        k = 0;
        while (m_mm_ack !== 1'b1 && k < 40) begin @(negedge clk_out_25MHZ); k++; end
        n_checks++;
        if (m_mm_ack !== 1'b1 || m_box_valid !== 1'b1 || m_mm_start !== 1'b0)
            $display("FAIL frame_mm_ack: ack=%b box_valid=%b mm_start=%b, want 1/1/0", m_mm_ack, m_box_valid, m_mm_start);
        else n_pass++;
        n_checks++;
        if ({m_x_min, m_x_max, m_y_min, m_y_max} !== e_box)
            $display("FAIL frame_box: got %h want %h", {m_x_min, m_x_max, m_y_min, m_y_max}, e_box);
        else n_pass++;
        n_checks++;
        if ({m_x_cen, m_y_cen} !== e_cen || m_box_empty !== e_empty)
            $display("FAIL frame_centre: cen=%0d,%0d empty=%b want %0d,%0d empty=%b",
                     m_x_cen, m_y_cen, m_box_empty, e_cen[17:9], e_cen[8:0], e_empty);
        else n_pass++;
        m_mdone = 1'b0;
        @(negedge clk_out_25MHZ);
        exp_fc = (exp_fc + 1) & 16'hFFFF;
        n_checks++;
        if (m_frame_count !== 16'(exp_fc))
            $display("FAIL frame_count: got %0d want %0d", m_frame_count, exp_fc);
        else n_pass++;
        @(negedge clk_out_25MHZ);
        n_checks++;
        if (m_bv_cnt - bv0 != 1)
            $display("FAIL frame_box_valid_pulses: got %0d want 1", m_bv_cnt - bv0);
        else n_pass++;
    endtask

    task automatic s_frame(input int md, input logic [8:0] a, input logic [8:0] b,
                           input logic [8:0] c, input logic [8:0] d);
        int k;
        int bv0;
        s_run = 1'b0;
        @(negedge clk_out_25MHZ);
        s_run = 1'b1;
        @(negedge clk_out_25MHZ);
        n_checks++;
        if (s_mm_start !== 1'b1 || s_state !== 4'd4)
            $display("FAIL skip_first_req: mm_start=%b state=%0d, want 1/4", s_mm_start, s_state);
        else n_pass++;
        repeat (md) @(negedge clk_out_25MHZ);
        n_checks++;
        if (s_state !== 4'd4 || s_err_flag !== 1'b0)
            $display("FAIL skip_no_timeout: state=%0d err=%b, want 4/0", s_state, s_err_flag);
        else n_pass++;
        s_xmin_i = a; s_xmax_i = b; s_ymin_i = c; s_ymax_i = d;
        s_mdone  = 1'b1;
        se_box   = {a, b, c, d};
        se_cen   = cen_of(a, b, c, d);
        se_empty = (a > b) || (c > d);
        bv0 = s_bv_cnt;
        k = 0;
        while (s_mm_ack !== 1'b1 && k < 40) begin @(negedge clk_out_25MHZ); k++; end
        n_checks++;
        if (s_box_valid !== 1'b1 || {s_x_min, s_x_max, s_y_min, s_y_max} !== se_box ||
            {s_x_cen, s_y_cen} !== se_cen || s_box_empty !== se_empty)
            $display("FAIL skip_box: valid=%b box=%h cen=%h empty=%b want 1 %h %h %b",
                     s_box_valid, {s_x_min, s_x_max, s_y_min, s_y_max}, {s_x_cen, s_y_cen},
                     s_box_empty, se_box, se_cen, se_empty);
        else n_pass++;
        s_mdone = 1'b0;
        @(negedge clk_out_25MHZ);
        s_exp_fc = (s_exp_fc + 1) & 16'hFFFF;
        n_checks++;
        if (s_frame_count !== 16'(s_exp_fc) || s_state !== 4'd0)
            $display("FAIL skip_count: count=%0d state=%0d want %0d/0", s_frame_count, s_state, s_exp_fc);
        else n_pass++;
        @(negedge clk_out_25MHZ);
        n_checks++;
        if (s_ph_cnt != 0 || s_photo_ack !== 1'b0 || s_bv_cnt - bv0 != 1 || s_err_code !== 2'd0)
            $display("FAIL skip_no_photo: ph_cycles=%0d ph_ack=%b pulses=%0d code=%0d want 0/0/1/0",
                     s_ph_cnt, s_photo_ack, s_bv_cnt - bv0, s_err_code);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_out_25MHZ);
        n_checks++;
        if ({m_photo_start, m_photo_ack, m_mm_start, m_mm_ack, m_box_valid, m_box_empty,
             m_err_flag, m_err_code, m_state, m_frame_count} !== '0 ||
            {m_x_min, m_x_max, m_y_min, m_y_max, m_x_cen, m_y_cen} !== '0)
            $display("FAIL reset_outputs: state=%0d count=%0d err=%b, want all 0", m_state, m_frame_count, m_err_flag);
        else n_pass++;
        n_checks++;
        if (s_state !== 4'd0 || s_mm_start !== 1'b0 || s_frame_count !== 16'd0)
            $display("FAIL reset_skip: state=%0d mm_start=%b count=%0d, want 0", s_state, s_mm_start, s_frame_count);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk_out_25MHZ);
    endtask

    task automatic test_single_frame();
        bit stayed;
        m_cont = 1'b0;
        m_run  = 1'b1;
        @(negedge clk_out_25MHZ);
        n_checks++;
        if (m_photo_start !== 1'b1 || m_state !== 4'd1)
            $display("FAIL single_latency: photo_start=%b state=%0d, want 1/1", m_photo_start, m_state);
        else n_pass++;
        m_frame(3, 10, 5, 1'b0, 9'd40, 9'd80, 9'd40, 9'd80);
        stayed = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (m_state !== 4'd0 || m_photo_start !== 1'b0) stayed = 1'b0;
            @(negedge clk_out_25MHZ);
        end
        n_checks++;
        if (!stayed || m_x_cen !== 9'd60 || m_y_cen !== 9'd60)
            $display("FAIL single_idle: stayed=%b cen=%0d,%0d, want 1 60,60", stayed, m_x_cen, m_y_cen);
        else n_pass++;
        m_run = 1'b0;
        @(negedge clk_out_25MHZ);
    endtask

    task automatic test_continuous();
        bit stayed;
        m_cont = 1'b1;
        m_run  = 1'b1;
        for (int f = 0; f < 4; f++)
            m_frame($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8), (f == 3),
                    9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                    9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
        stayed = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (m_state !== 4'd0 || m_photo_start !== 1'b0) stayed = 1'b0;
            @(negedge clk_out_25MHZ);
        end
        n_checks++;
        if (!stayed || m_frame_count !== 16'd5)
            $display("FAIL continuous_stop: stayed_idle=%b count=%0d, want 1/5", stayed, m_frame_count);
        else n_pass++;
        m_cont = 1'b0;
    endtask

    task automatic test_photo_error();
        int k;
        m_run = 1'b1;
        k = 0;
        while (m_photo_start !== 1'b1 && k < 40) begin @(negedge clk_out_25MHZ); k++; end
        m_pst = 1'b1;
        @(negedge clk_out_25MHZ);
        m_pst  = 1'b0;
        m_perr = 1'b1;
        @(negedge clk_out_25MHZ);
        m_perr = 1'b0;
        m_run  = 1'b0;
        n_checks++;
        if (m_err_flag !== 1'b1 || m_err_code !== 2'd1 || m_state !== 4'd7 ||
            {m_photo_start, m_photo_ack, m_mm_start, m_mm_ack} !== 4'b0)
            $display("FAIL photo_error: err=%b code=%0d state=%0d, want 1/1/7", m_err_flag, m_err_code, m_state);
        else n_pass++;
        n_checks++;
        if (m_frame_count !== 16'(exp_fc) || {m_x_min, m_x_max, m_y_min, m_y_max} !== e_box)
            $display("FAIL photo_error_retain: count=%0d box=%h want %0d %h",
                     m_frame_count, {m_x_min, m_x_max, m_y_min, m_y_max}, exp_fc, e_box);
        else n_pass++;
        m_clr = 1'b1;
        @(negedge clk_out_25MHZ);
        m_clr = 1'b0;
        n_checks++;
        if (m_state !== 4'd0 || m_err_flag !== 1'b0 || m_err_code !== 2'd0)
            $display("FAIL clear_err: state=%0d err=%b code=%0d, want 0/0/0", m_state, m_err_flag, m_err_code);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int k;
        m_run = 1'b1;
        k = 0;
        while (m_photo_start !== 1'b1 && k < 40) begin @(negedge clk_out_25MHZ); k++; end
        k = 0;
        while (m_err_flag !== 1'b1 && k < 40) begin @(negedge clk_out_25MHZ); k++; end
        m_run = 1'b0;
        n_checks++;
        if (k != 16 || m_err_code !== 2'd3 || m_state !== 4'd7)
            $display("FAIL ph_timeout: cycles=%0d code=%0d state=%0d, want 16/3/7", k, m_err_code, m_state);
        else n_pass++;
        m_clr = 1'b1;
        @(negedge clk_out_25MHZ);
        m_clr = 1'b0;
        @(negedge clk_out_25MHZ);
    endtask

    task automatic test_mm_collision();
        int k;
        int bv0;
        m_run = 1'b1;
        k = 0;
        while (m_photo_start !== 1'b1 && k < 40) begin @(negedge clk_out_25MHZ); k++; end
        m_pst = 1'b1;
        @(negedge clk_out_25MHZ);
        m_pst   = 1'b0;
        m_pdone = 1'b1;
        k = 0;
        while (m_photo_ack !== 1'b1 && k < 40) begin @(negedge clk_out_25MHZ); k++; end
        m_pdone = 1'b0;
        k = 0;
        while (m_mm_start !== 1'b1 && k < 40) begin @(negedge clk_out_25MHZ); k++; end
        m_xmin_i = ~e_box[35:27]; m_xmax_i = ~e_box[26:18];
        m_ymin_i = ~e_box[17:9];  m_ymax_i = ~e_box[8:0];
        m_mdone = 1'b1;
        m_merr  = 1'b1;
        bv0 = m_bv_cnt;
        @(negedge clk_out_25MHZ);
        m_mdone = 1'b0;
        m_merr  = 1'b0;
        m_run   = 1'b0;
        n_checks++;
        if (m_err_code !== 2'd2 || m_state !== 4'd7 || m_mm_ack !== 1'b0)
            $display("FAIL mm_collision: code=%0d state=%0d mm_ack=%b, want 2/7/0", m_err_code, m_state, m_mm_ack);
        else n_pass++;
        @(negedge clk_out_25MHZ);
        n_checks++;
        if ({m_x_min, m_x_max, m_y_min, m_y_max} !== e_box || m_bv_cnt != bv0)
            $display("FAIL mm_collision_box: box=%h pulses=%0d want %h 0",
                     {m_x_min, m_x_max, m_y_min, m_y_max}, m_bv_cnt - bv0, e_box);
        else n_pass++;
        m_clr = 1'b1;
        @(negedge clk_out_25MHZ);
        m_clr = 1'b0;
        @(negedge clk_out_25MHZ);
    endtask

    task automatic test_async_reset();
        int k;
        m_run = 1'b1;
        k = 0;
        while (m_photo_start !== 1'b1 && k < 40) begin @(negedge clk_out_25MHZ); k++; end
        m_pst = 1'b1;
        @(negedge clk_out_25MHZ);
        m_pst = 1'b0;
        reset = 1'b1;
        #1;
        exp_fc = 0;
        e_box  = '0;
        n_checks++;
        if (m_state !== 4'd0 || m_frame_count !== 16'd0 || m_photo_start !== 1'b0 ||
            {m_x_min, m_x_max, m_y_min, m_y_max} !== e_box || {m_x_cen, m_y_cen} !== 18'd0)
            $display("FAIL async_reset: state=%0d count=%0d box=%h, want 0", m_state, m_frame_count,
                     {m_x_min, m_x_max, m_y_min, m_y_max});
        else n_pass++;
        @(negedge clk_out_25MHZ);
        reset = 1'b0;
        m_run = 1'b0;
        @(negedge clk_out_25MHZ);
        m_run = 1'b1;
        m_frame($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8), 1'b1,
                9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
    endtask

    task automatic test_skip_photo();
        s_cont = 1'b0;
        s_frame(40, 9'd100, 9'd20, 9'd30, 9'd40);
        n_checks++;
        if (s_box_empty !== 1'b1 || s_x_cen !== 9'd60 || s_y_cen !== 9'd35)
            $display("FAIL skip_empty_box: empty=%b cen=%0d,%0d, want 1 60,35", s_box_empty, s_x_cen, s_y_cen);
        else n_pass++;
        s_run = 1'b0;
        force dut_s.frame_cnt_q = 16'hFFFF;
        @(negedge clk_out_25MHZ);
        release dut_s.frame_cnt_q;
        @(negedge clk_out_25MHZ);
        s_exp_fc = 16'hFFFF;
        n_checks++;
        if (s_frame_count !== 16'hFFFF)
            $display("FAIL skip_preload: count=%h want ffff", s_frame_count);
        else n_pass++;
        s_frame(3, 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
    endtask

    initial begin
        reset = 1'b1;
        {m_run, m_cont, m_clr, m_pst, m_pdone, m_perr, m_mdone, m_merr} = '0;
        {s_run, s_cont, s_clr, s_pst, s_pdone, s_perr, s_mdone, s_merr} = '0;
        {m_xmin_i, m_xmax_i, m_ymin_i, m_ymax_i} = '0;
        {s_xmin_i, s_xmax_i, s_ymin_i, s_ymax_i} = '0;
        test_reset();
        test_single_frame();
        test_continuous();
        test_photo_error();
        test_timeout();
        test_mm_collision();
        test_async_reset();
        test_skip_photo();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
